// File: rtl/mem_stage_seq_pkg.sv
// Shared LC-3b types for the MEM-stage sequencer: opcodes, FSM states,
// MAR/MDR mux select codes and a memory-op classifier.
package lc3b_types;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   typedef enum logic [1:0] {
      IDLE,
      ACC1,
      ACC2,
      DONE
   } mem_seq_state_t;

   localparam logic [2:0] MARMUX_ALU   = 3'd0;
   localparam logic [2:0] MARMUX_PC    = 3'd1;
   localparam logic [2:0] MARMUX_BRADD = 3'd2;
   localparam logic [2:0] MARMUX_RDATA = 3'd3;
   localparam logic [2:0] MARMUX_TRAP  = 3'd4;

   localparam logic [1:0] MDRMUX_ALU   = 2'd0;
   localparam logic [1:0] MDRMUX_RDATA = 2'd1;
   localparam logic [1:0] MDRMUX_SR1HI = 2'd2;

   function automatic logic is_mem_op(input logic [3:0] op);
      logic r;
      r = 1'b0;
      case (op)
         op_ldr, op_ldb, op_str, op_stb,
         op_ldi, op_sti, op_trap: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_stage_seq_wait_timer.sv
// Watchdog for port-b accesses: counts strobe cycles without resp_b.
// Ports: clk, reset, strobe_i, resp_i, clear_i in; timeout_o sticky out.
module mem_wait_timer #(
   parameter int MAX_WAIT = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic strobe_i,
   input  logic resp_i,
   input  logic clear_i,
   output logic timeout_o
);

   localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

   generate
      if (MAX_WAIT > 0) begin : g_wd
         localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

         logic [CW-1:0] cnt_q, cnt_d;
         logic          err_q;
         logic          hit;

         // Counter saturates at LIMIT so it never wraps on a long wait.
         always_comb begin
            cnt_d = cnt_q;
            if (!strobe_i || resp_i || clear_i)
               cnt_d = '0;
            else if (cnt_q != LIMIT)
               cnt_d = cnt_q + 1'b1;
         end

         // Flag is visible in the cycle the count reaches the limit.
         assign hit = (cnt_d == LIMIT);

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt_q <= '0;
               err_q <= 1'b0;
            end else begin
               cnt_q <= cnt_d;
               if (hit)
                  err_q <= 1'b1;
            end
         end

         assign timeout_o = err_q | hit;
      end else begin : g_off
         logic unused;
         assign unused = ^{clk, reset, strobe_i, resp_i, clear_i};
         assign timeout_o = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/mem_stage_seq.sv
// LC-3b MEM-stage sequencer: port-b handshake, LDI/STI indirection, stall.
// Ports: valid_in/opcode/ea_lsb/mar_lsb/resp_b in; strobes, mux/load ctl out.
module mem_stage_seq
   import lc3b_types::*;
#(
   parameter int MAX_WAIT = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       valid_in,
   input  logic [3:0] opcode,
   input  logic       ea_lsb,
   input  logic       mar_lsb,
   input  logic       resp_b,
   output logic       mem_read,
   output logic       mem_write,
   output logic [1:0] mem_byte_enable,
   output logic       load_mar,
   output logic [2:0] marmux_sel,
   output logic       load_mdr,
   output logic [1:0] mdrmux_sel,
   output logic       stall,
   output logic       done,
   output logic       timeout_err
);

   mem_seq_state_t state_q, state_d;
   lc3b_opcode     op_q, op_d;
   logic           accept;
   logic           indirect;

   // Accept is gated by reset so all outputs are low while it is held.
   assign accept = !reset && (state_q == IDLE)
                 && valid_in && is_mem_op(opcode);

   assign op_d     = accept ? lc3b_opcode'(opcode) : op_q;
   assign indirect = (op_q == op_ldi) || (op_q == op_sti);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= op_br;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = ACC1;
         ACC1: if (resp_b) state_d = indirect ? ACC2 : DONE;
         ACC2: if (resp_b) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_byte_enable = 2'b00;
      load_mar        = 1'b0;
      marmux_sel      = MARMUX_ALU;
      load_mdr        = 1'b0;
      mdrmux_sel      = MDRMUX_ALU;
      stall           = 1'b0;
      done            = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               stall    = 1'b1;
               load_mar = 1'b1;
               if (opcode == op_trap)
                  marmux_sel = MARMUX_TRAP;
               case (opcode)
                  op_str, op_sti: load_mdr = 1'b1;
                  op_stb: begin
                     load_mdr   = 1'b1;
                     mdrmux_sel = ea_lsb ? MDRMUX_SR1HI
                                         : MDRMUX_ALU;
                  end
                  default: ;
               endcase
            end
         end
         ACC1: begin
            stall = 1'b1;
            if ((op_q == op_str) || (op_q == op_stb))
               mem_write = 1'b1;
            else
               mem_read = 1'b1;
            if (resp_b) begin
               case (op_q)
                  op_ldr, op_ldb, op_trap: begin
                     load_mdr   = 1'b1;
                     mdrmux_sel = MDRMUX_RDATA;
                  end
                  op_ldi, op_sti: begin
                     load_mar   = 1'b1;
                     marmux_sel = MARMUX_RDATA;
                  end
                  default: ;
               endcase
            end
         end
         ACC2: begin
            stall = 1'b1;
            if (op_q == op_sti)
               mem_write = 1'b1;
            else
               mem_read = 1'b1;
            if (resp_b && (op_q == op_ldi)) begin
               load_mdr   = 1'b1;
               mdrmux_sel = MDRMUX_RDATA;
            end
         end
         DONE: done = 1'b1;
         default: ;
      endcase
      if (mem_write) begin
         if (op_q == op_stb)
            mem_byte_enable = mar_lsb ? 2'b10 : 2'b01;
         else
            mem_byte_enable = 2'b11;
      end
   end

   mem_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .strobe_i  (mem_read | mem_write),
      .resp_i    (resp_b),
      .clear_i   (state_d != state_q),
      .timeout_o (timeout_err)
   );

endmodule

// File: tb/tb_mem_stage_seq.sv
// Bench for mem_stage_seq: directed vector table, corner sequences and
// random traffic against a transaction-queue reference model.
module tb_mem_stage_seq;

   localparam int MAXW = 4;

   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_LDB  = 4'd2;
   localparam logic [3:0] OP_STB  = 4'd3;
   localparam logic [3:0] OP_LDR  = 4'd6;
   localparam logic [3:0] OP_STR  = 4'd7;
   localparam logic [3:0] OP_LDI  = 4'd10;
   localparam logic [3:0] OP_STI  = 4'd11;
   localparam logic [3:0] OP_TRAP = 4'd15;

   typedef struct packed {
      logic       mr;
      logic       mw;
      logic [1:0] be;
      logic       lmar;
      logic [2:0] msel;
      logic       lmdr;
      logic [1:0] dsel;
      logic       st;
      logic       dn;
      logic       te;
   } outs_t;

   typedef struct {
      logic       v;
      logic [3:0] op;
      logic       ea;
      logic       mar;
      logic       resp;
      outs_t      e;
   } vec_t;

   // One pending port-b access of the reference model.
   typedef struct {
      bit wr;
      bit byt;
      bit to_mar;
   } acc_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       valid_in;
   logic [3:0] opcode;
   logic       ea_lsb, mar_lsb, resp_b;
   logic       mem_read, mem_write, load_mar, load_mdr;
   logic [1:0] mem_byte_enable, mdrmux_sel;
   logic [2:0] marmux_sel;
   logic       stall, done, timeout_err;
   outs_t      act;

   int n_chk = 0;
   int n_fail = 0;

   acc_t aq[$];
   bit   m_done;
   int   m_wait;
   bit   m_terr;

   always #5 clk = ~clk;

   mem_stage_seq #(.MAX_WAIT(MAXW)) dut (
      .clk             (clk),
      .reset           (reset),
      .valid_in        (valid_in),
      .opcode          (opcode),
      .ea_lsb          (ea_lsb),
      .mar_lsb         (mar_lsb),
      .resp_b          (resp_b),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .load_mar        (load_mar),
      .marmux_sel      (marmux_sel),
      .load_mdr        (load_mdr),
      .mdrmux_sel      (mdrmux_sel),
      .stall           (stall),
      .done            (done),
      .timeout_err     (timeout_err)
   );

   assign act = {mem_read, mem_write, mem_byte_enable, load_mar,
                 marmux_sel, load_mdr, mdrmux_sel, stall, done,
                 timeout_err};

   function automatic outs_t mk(
      input logic mr, input logic mw, input logic [1:0] be,
      input logic lmar, input logic [2:0] msel,
      input logic lmdr, input logic [1:0] dsel,
      input logic st, input logic dn, input logic te);
      outs_t o;
      o = {mr, mw, be, lmar, msel, lmdr, dsel, st, dn, te};
      return o;
   endfunction

   task automatic check(input string nm, input outs_t e);
      n_chk++;
      if (act !== e) begin
         n_fail++;
         $display("FAIL %s: got mr%b mw%b be%b lmar%b msel%0d lmdr%b dsel%0d st%b dn%b te%b, want mr%b mw%b be%b lmar%b msel%0d lmdr%b dsel%0d st%b dn%b te%b",
                  nm, act.mr, act.mw, act.be, act.lmar, act.msel,
                  act.lmdr, act.dsel, act.st, act.dn, act.te,
                  e.mr, e.mw, e.be, e.lmar, e.msel, e.lmdr, e.dsel,
                  e.st, e.dn, e.te);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] op,
                        input logic ea, input logic mar,
                        input logic resp);
      valid_in = v;
      opcode   = op;
      ea_lsb   = ea;
      mar_lsb  = mar;
      resp_b   = resp;
   endtask

   // Inputs are applied just after posedge; outputs compared at negedge.
   task automatic step(input string nm, input outs_t e);
      @(negedge clk);
      check(nm, e);
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      aq.delete();
      m_done = 0;
      m_wait = 0;
      m_terr = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b1, OP_LDR, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      check("reset_outs", '0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
      model_reset();
   endtask

   // Reference model: each memory op is a list of port-b accesses; the
   // stage is busy while the list is non-empty and pulses done after it.
   task automatic model(input logic v, input logic [3:0] op,
                        input logic ea, input logic mar,
                        input logic resp, output outs_t e);
      acc_t a;
      e = '0;
      if (m_done) begin
         e.dn   = 1'b1;
         m_done = 0;
      end else if (aq.size() > 0) begin
         a    = aq[0];
         e.st = 1'b1;
         if (a.wr) begin
            e.mw = 1'b1;
            e.be = a.byt ? (mar ? 2'b10 : 2'b01) : 2'b11;
         end else begin
            e.mr = 1'b1;
         end
         if (resp) begin
            m_wait = 0;
            if (!a.wr && a.to_mar) begin
               e.lmar = 1'b1;
               e.msel = 3'd3;
            end else if (!a.wr) begin
               e.lmdr = 1'b1;
               e.dsel = 2'd1;
            end
            void'(aq.pop_front());
            if (aq.size() == 0)
               m_done = 1;
         end else begin
            m_wait++;
            if (m_wait >= MAXW)
               m_terr = 1;
         end
      end else if (v) begin
         case (op)
            OP_LDR, OP_LDB, OP_TRAP:
               aq.push_back('{0, 0, 0});
            OP_STR: begin
               e.lmdr = 1'b1;
               aq.push_back('{1, 0, 0});
            end
            OP_STB: begin
               e.lmdr = 1'b1;
               e.dsel = ea ? 2'd2 : 2'd0;
               aq.push_back('{1, 1, 0});
            end
            OP_LDI: begin
               aq.push_back('{0, 0, 1});
               aq.push_back('{0, 0, 0});
            end
            OP_STI: begin
               e.lmdr = 1'b1;
               aq.push_back('{0, 0, 1});
               aq.push_back('{1, 0, 0});
            end
            default: ;
         endcase
         if (aq.size() > 0) begin
            e.st   = 1'b1;
            e.lmar = 1'b1;
            e.msel = (op == OP_TRAP) ? 3'd4 : 3'd0;
         end
      end
      e.te = m_terr;
   endtask

   vec_t tbl[$];

   initial begin
      outs_t e;
      logic  v, ea, mar, rsp;
      logic [3:0] op;

      reset = 1'b1;
      drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
      #1;
      do_reset();

      // LDR with two wait cycles; live opcode changes are ignored.
      tbl.push_back('{1, OP_LDR, 0, 0, 0,
                      mk(0,0,2'b00,1,0,0,0,1,0,0)});
      tbl.push_back('{1, OP_ADD, 0, 0, 0,
                      mk(1,0,2'b00,0,0,0,0,1,0,0)});
      tbl.push_back('{0, OP_ADD, 0, 0, 0,
                      mk(1,0,2'b00,0,0,0,0,1,0,0)});
      tbl.push_back('{0, OP_ADD, 0, 0, 1,
                      mk(1,0,2'b00,0,0,1,1,1,0,0)});
      tbl.push_back('{0, OP_ADD, 0, 0, 0,
                      mk(0,0,2'b00,0,0,0,0,0,1,0)});
      // STB to odd byte, zero wait.
      tbl.push_back('{1, OP_STB, 1, 0, 0,
                      mk(0,0,2'b00,1,0,1,2,1,0,0)});
      tbl.push_back('{0, OP_ADD, 0, 1, 1,
                      mk(0,1,2'b10,0,0,0,0,1,0,0)});
      tbl.push_back('{0, OP_ADD, 0, 0, 0,
                      mk(0,0,2'b00,0,0,0,0,0,1,0)});
      // LDI, zero wait.
      tbl.push_back('{1, OP_LDI, 0, 0, 0,
                      mk(0,0,2'b00,1,0,0,0,1,0,0)});
      tbl.push_back('{0, OP_ADD, 0, 0, 1,
                      mk(1,0,2'b00,1,3,0,0,1,0,0)});
      tbl.push_back('{0, OP_ADD, 0, 0, 1,
                      mk(1,0,2'b00,0,0,1,1,1,0,0)});
      tbl.push_back('{0, OP_ADD, 0, 0, 0,
                      mk(0,0,2'b00,0,0,0,0,0,1,0)});
      // ADD ignored (resp_b in IDLE too), then TRAP.
      tbl.push_back('{1, OP_ADD, 1, 1, 1,
                      mk(0,0,2'b00,0,0,0,0,0,0,0)});
      tbl.push_back('{1, OP_TRAP, 0, 0, 0,
                      mk(0,0,2'b00,1,4,0,0,1,0,0)});
      tbl.push_back('{0, OP_ADD, 0, 0, 1,
                      mk(1,0,2'b00,0,0,1,1,1,0,0)});
      tbl.push_back('{0, OP_ADD, 0, 0, 0,
                      mk(0,0,2'b00,0,0,0,0,0,1,0)});
      // STR word write at odd MAR still writes both bytes.
      tbl.push_back('{1, OP_STR, 1, 0, 0,
                      mk(0,0,2'b00,1,0,1,0,1,0,0)});
      tbl.push_back('{0, OP_ADD, 0, 1, 1,
                      mk(0,1,2'b11,0,0,0,0,1,0,0)});
      tbl.push_back('{0, OP_ADD, 0, 0, 0,
                      mk(0,0,2'b00,0,0,0,0,0,1,0)});
      // STB to even byte, back-to-back after DONE.
      tbl.push_back('{1, OP_STB, 0, 0, 0,
                      mk(0,0,2'b00,1,0,1,0,1,0,0)});
      tbl.push_back('{0, OP_ADD, 0, 0, 1,
                      mk(0,1,2'b01,0,0,0,0,1,0,0)});
      tbl.push_back('{0, OP_ADD, 0, 0, 0,
                      mk(0,0,2'b00,0,0,0,0,0,1,0)});

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].v, tbl[i].op, tbl[i].ea, tbl[i].mar,
               tbl[i].resp);
         step($sformatf("vec%0d", i), tbl[i].e);
      end

      // Watchdog: LDR with resp_b withheld for 10 strobe cycles.
      do_reset();
      drive(1'b1, OP_LDR, 1'b0, 1'b0, 1'b0);
      step("wd_accept", mk(0,0,2'b00,1,0,0,0,1,0,0));
      for (int k = 1; k <= 10; k++) begin
         drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
         step($sformatf("wd_wait%0d", k),
              mk(1,0,2'b00,0,0,0,0,1,0,(k >= MAXW)));
      end
      drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b1);
      step("wd_resp", mk(1,0,2'b00,0,0,1,1,1,0,1));
      drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
      step("wd_done", mk(0,0,2'b00,0,0,0,0,0,1,1));
      step("wd_sticky", mk(0,0,2'b00,0,0,0,0,0,0,1));

      // STI with reset asserted during the second access.
      do_reset();
      drive(1'b1, OP_STI, 1'b0, 1'b0, 1'b0);
      step("sti_accept", mk(0,0,2'b00,1,0,1,0,1,0,0));
      drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b1);
      step("sti_acc1", mk(1,0,2'b00,1,3,0,0,1,0,0));
      drive(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("sti_acc2", mk(0,1,2'b11,0,0,0,0,1,0,0));
      #1;
      reset = 1'b1;
      #1;
      check("sti_async_rst", '0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step("sti_post_rst0", '0);
      step("sti_post_rst1", '0);

      // Random traffic against the reference model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 249)
            do_reset();
         v   = ($urandom_range(0, 3) != 0);
         op  = 4'($urandom_range(0, 15));
         ea  = 1'($urandom_range(0, 1));
         mar = 1'($urandom_range(0, 1));
         rsp = ($urandom_range(0, 2) != 0);
         drive(v, op, ea, mar, rsp);
         model(v, op, ea, mar, rsp, e);
         step($sformatf("rnd%0d", i), e);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
